hazard_stall_unit: RTL and testbench

//   Control end of the D->E pipeline register: decides every cycle whether D stalls.

---
 rtl/hazard_stall_unit_pkg.sv | 59 +++++
 rtl/hazard_stall_unit_instr_tdecode.sv | 115 +++++++++++
 rtl/hazard_stall_unit.sv | 126 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit_pkg
// Brief    : Shared MIPS definitions for the hazard/stall unit: opcode and
//            funct codes, the 2-bit Tuse/Tnew type, and the pipeline-age helper.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_stall_unit_pkg;

    // Width of the Tuse/Tnew timing values
    localparam int T_W   = 2;
    // Width of the multiply/divide busy counter
    localparam int CNT_W = 4;

    typedef logic [T_W-1:0] tval_t;

    // An operand the instruction does not read. It is never less than any Tnew.
    localparam tval_t TUSE_NONE = 2'd3;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // Tnew one stage further down the pipe: one cycle closer, floored at 0
    function automatic tval_t tnew_age(input tval_t t);
        return (t == '0) ? '0 : t - tval_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_instr_tdecode.sv
`default_nettype none
// ============================================================================
// Module   : instr_tdecode
// Brief    : Combinational per-stage decode: register fields, write address,
//            operand Tuse, E-stage Tnew and multiply/divide class flags.
// Revision : 1.0 - initial release
// ============================================================================
module instr_tdecode
    import hazard_stall_unit_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_wa,
    output tval_t       o_tuse_rs,
    output tval_t       o_tuse_rt,
    output tval_t       o_tnew_e,
    output logic        o_is_md,
    output logic        o_is_mdstart,
    output logic        o_is_div
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_rd     = i_instr[15:11];
    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];
    // The shift amount has no bearing on hazards
    assign w_unused = ^i_instr[10:6];

    // Classify the instruction; anything unrecognised reads and writes nothing
    always_comb begin
        o_wa         = 5'd0;
        o_tuse_rs    = TUSE_NONE;
        o_tuse_rt    = TUSE_NONE;
        o_tnew_e     = 2'd0;
        o_is_md      = 1'b0;
        o_is_mdstart = 1'b0;
        o_is_div     = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        o_tuse_rs = 2'd1;
                        o_tuse_rt = 2'd1;
                        o_wa      = w_rd;
                        o_tnew_e  = 2'd1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        o_tuse_rt = 2'd1;
                        o_wa      = w_rd;
                        o_tnew_e  = 2'd1;
                    end
                    FN_JR: begin
                        o_tuse_rs = 2'd0;
                    end
                    FN_MFHI, FN_MFLO: begin
                        o_wa     = w_rd;
                        o_tnew_e = 2'd1;
                        o_is_md  = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        o_tuse_rs = 2'd1;
                        o_is_md   = 1'b1;
                    end
                    FN_MULT, FN_MULTU: begin
                        o_tuse_rs    = 2'd1;
                        o_tuse_rt    = 2'd1;
                        o_is_md      = 1'b1;
                        o_is_mdstart = 1'b1;
                    end
                    FN_DIV, FN_DIVU: begin
                        o_tuse_rs    = 2'd1;
                        o_tuse_rt    = 2'd1;
                        o_is_md      = 1'b1;
                        o_is_mdstart = 1'b1;
                        o_is_div     = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_BEQ: begin
                o_tuse_rs = 2'd0;
                o_tuse_rt = 2'd0;
            end
            OP_ORI, OP_LUI: begin
                o_tuse_rs = 2'd1;
                o_wa      = o_rt;
                o_tnew_e  = 2'd1;
            end
            OP_LW: begin
                o_tuse_rs = 2'd1;
                o_wa      = o_rt;
                o_tnew_e  = 2'd2;
            end
            OP_SW: begin
                o_tuse_rs = 2'd1;
                o_tuse_rt = 2'd2;
            end
            OP_JAL: begin
                o_wa     = 5'd31;
                o_tnew_e = 2'd0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : D-stage stall decision. Compares D operand Tuse against E/M Tnew,
//            interlocks on the multi-cycle mult/div unit, and drives PC/D write
//            enables plus the E-register flush.
//            Optional: STALL_COUNT_EN enables a 32-bit stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_Instr,
    input  logic [31:0] E_Instr,
    input  logic [31:0] M_Instr,
    output logic        PC_WrEn,
    output logic        D_WrEn,
    output logic        E_WrEn,
    output logic        E_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles
);

    logic [4:0] d_rs, d_rt, d_wa, e_rs, e_rt, e_wa, m_rs, m_rt, m_wa;
    tval_t      d_tuse_rs, d_tuse_rt, d_tnew_e;
    tval_t      e_tuse_rs, e_tuse_rt, e_tnew;
    tval_t      m_tuse_rs, m_tuse_rt, m_tnew_e, m_tnew;
    logic       d_is_md, d_is_mdstart, d_is_div;
    logic       e_is_md, e_is_mdstart, e_is_div;
    logic       m_is_md, m_is_mdstart, m_is_div;

    logic             stall_rs, stall_rt, stall_mdu, stall;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_unused;

    instr_tdecode u_dec_d (
        .i_instr(D_Instr), .o_rs(d_rs), .o_rt(d_rt), .o_wa(d_wa),
        .o_tuse_rs(d_tuse_rs), .o_tuse_rt(d_tuse_rt), .o_tnew_e(d_tnew_e),
        .o_is_md(d_is_md), .o_is_mdstart(d_is_mdstart), .o_is_div(d_is_div)
    );

    instr_tdecode u_dec_e (
        .i_instr(E_Instr), .o_rs(e_rs), .o_rt(e_rt), .o_wa(e_wa),
        .o_tuse_rs(e_tuse_rs), .o_tuse_rt(e_tuse_rt), .o_tnew_e(e_tnew),
        .o_is_md(e_is_md), .o_is_mdstart(e_is_mdstart), .o_is_div(e_is_div)
    );

    instr_tdecode u_dec_m (
        .i_instr(M_Instr), .o_rs(m_rs), .o_rt(m_rt), .o_wa(m_wa),
        .o_tuse_rs(m_tuse_rs), .o_tuse_rt(m_tuse_rt), .o_tnew_e(m_tnew_e),
        .o_is_md(m_is_md), .o_is_mdstart(m_is_mdstart), .o_is_div(m_is_div)
    );

    // Decode outputs that no stage-specific check needs
    assign w_unused = ^{d_wa, d_tnew_e, d_is_mdstart, d_is_div,
                        e_rs, e_rt, e_tuse_rs, e_tuse_rt, e_is_md,
                        m_rs, m_rt, m_tuse_rs, m_tuse_rt,
                        m_is_md, m_is_mdstart, m_is_div};

    assign m_tnew = tnew_age(m_tnew_e);

    // Same-cycle stall decision; rs/rt != 0 also masks writes to $0
    always_comb begin
        stall_rs  = (d_rs != 5'd0) &&
                    (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                     ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
        stall_rt  = (d_rt != 5'd0) &&
                    (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                     ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
        stall_mdu = d_is_md && (e_is_mdstart || (cnt_q != '0));
        stall     = stall_rs || stall_rt || stall_mdu;
    end

    assign PC_WrEn  = ~stall;
    assign D_WrEn   = ~stall;
    assign E_WrEn   = 1'b1;
    assign E_flush  = stall;
    assign mdu_busy = (cnt_q != '0);

    // Busy counter next state: a new start reloads, otherwise count down to 0
    always_comb begin
        cnt_d = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (e_is_mdstart) begin
            cnt_d = e_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Busy counter register
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count every edge at which D is held; wraps naturally at 2^32
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (reset) begin
            stall_cnt_d = '0;
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Directed, table-driven bench for hazard_stall_unit plus hand
//            sequences for mult/div interlock, reset mid-busy and stall count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_Instr, E_Instr, M_Instr;
    logic        PC_WrEn, D_WrEn, E_WrEn, E_flush, mdu_busy;
    logic [31:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    hazard_stall_unit dut (
        .clk(clk), .reset(reset),
        .D_Instr(D_Instr), .E_Instr(E_Instr), .M_Instr(M_Instr),
        .PC_WrEn(PC_WrEn), .D_WrEn(D_WrEn), .E_WrEn(E_WrEn),
        .E_flush(E_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs,
                                          input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    localparam logic [31:0] JAL = {6'h03, 26'h0};

    task automatic check_ctl(input string nm, input logic exp_stall);
        logic [3:0] act;
        logic [3:0] exp;
        act = {PC_WrEn, D_WrEn, E_WrEn, E_flush};
        exp = {~exp_stall, ~exp_stall, 1'b1, exp_stall};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: {PC_WrEn,D_WrEn,E_WrEn,E_flush} got %b want %b", nm, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] m;
        logic        stall;
    } vec_t;

    vec_t vt[19];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        vt[0]  = '{"nops",          32'h0, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{"lwE_addD",      rtype(1,1,2,6'h20), itype(6'h23,0,1,16'h0), 32'h0, 1'b1};
        vt[2]  = '{"lwM_addD",      rtype(1,1,2,6'h20), 32'h0, itype(6'h23,0,1,16'h0), 1'b0};
        vt[3]  = '{"lwE_beqD",      itype(6'h04,1,0,16'h4), itype(6'h23,0,1,16'h0), 32'h0, 1'b1};
        vt[4]  = '{"lwM_beqD",      itype(6'h04,1,0,16'h4), 32'h0, itype(6'h23,0,1,16'h0), 1'b1};
        vt[5]  = '{"addE_beqD",     itype(6'h04,1,0,16'h4), rtype(2,3,1,6'h20), 32'h0, 1'b1};
        vt[6]  = '{"addM_beqD",     itype(6'h04,1,0,16'h4), 32'h0, rtype(2,3,1,6'h20), 1'b0};
        vt[7]  = '{"lw0E_addD",     rtype(0,0,2,6'h20), itype(6'h23,0,0,16'h0), 32'h0, 1'b0};
        vt[8]  = '{"lwE_swD_rt",    itype(6'h2b,2,1,16'h0), itype(6'h23,0,1,16'h0), 32'h0, 1'b0};
        vt[9]  = '{"lwE_swD_rs",    itype(6'h2b,1,3,16'h0), itype(6'h23,0,1,16'h0), 32'h0, 1'b1};
        vt[10] = '{"jalE_jrD",      rtype(31,0,0,6'h08), JAL, 32'h0, 1'b0};
        vt[11] = '{"jalM_jrD",      rtype(31,0,0,6'h08), 32'h0, JAL, 1'b0};
        vt[12] = '{"lwE_jrD",       rtype(31,0,0,6'h08), itype(6'h23,0,31,16'h0), 32'h0, 1'b1};
        vt[13] = '{"oriE_oriD",     itype(6'h0d,4,5,16'h1), itype(6'h0d,0,4,16'h1), 32'h0, 1'b0};
        vt[14] = '{"oriE_beqD_rt",  itype(6'h04,0,4,16'h1), itype(6'h0d,0,4,16'h1), 32'h0, 1'b1};
        vt[15] = '{"swE_addD",      rtype(1,1,2,6'h20), itype(6'h2b,1,1,16'h0), 32'h0, 1'b0};
        vt[16] = '{"lwE_mthiD",     rtype(1,0,0,6'h11), itype(6'h23,0,1,16'h0), 32'h0, 1'b1};
        vt[17] = '{"lwE_multD_rt",  rtype(1,2,0,6'h18), itype(6'h23,0,2,16'h0), 32'h0, 1'b1};
        vt[18] = '{"lwM_multD_rt",  rtype(1,2,0,6'h18), 32'h0, itype(6'h23,0,2,16'h0), 1'b0};

        // ---------------- reset ----------------
        reset   = 1'b1;
        D_Instr = 32'h0;
        E_Instr = 32'h0;
        M_Instr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_ctl("reset_ctl", 1'b0);
        check_val("reset_busy", {31'b0, mdu_busy}, 32'd0);
        check_val("reset_stall_cycles", stall_cycles, 32'd0);
        reset = 1'b0;
        next_cycle();

        // ---------------- table ----------------
        for (int i = 0; i < 19; i++) begin
            D_Instr = vt[i].d;
            E_Instr = vt[i].e;
            M_Instr = vt[i].m;
            #2;
            check_ctl(vt[i].name, vt[i].stall);
            next_cycle();
        end
        D_Instr = 32'h0; E_Instr = 32'h0; M_Instr = 32'h0;
        next_cycle();
        check_val("table_busy_idle", {31'b0, mdu_busy}, 32'd0);

        // ---------------- mult in E, mflo in D ----------------
        E_Instr = rtype(1, 2, 0, 6'h18);
        D_Instr = rtype(0, 0, 3, 6'h12);
        #2;
        check_ctl("mult_start", 1'b1);
        check_val("mult_start_busy", {31'b0, mdu_busy}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            E_Instr = 32'h0;   // bubble behind the stalled mflo
            #1;
            check_ctl($sformatf("mult_busy%0d", k), 1'b1);
            check_val($sformatf("mult_busy%0d_flag", k), {31'b0, mdu_busy}, 32'd1);
        end
        next_cycle();
        check_ctl("mflo_issue", 1'b0);
        check_val("mult_done_busy", {31'b0, mdu_busy}, 32'd0);

        // ---------------- div in E, reset on busy cycle 3 ----------------
        E_Instr = rtype(1, 2, 0, 6'h1a);
        D_Instr = rtype(0, 0, 3, 6'h10);
        #2;
        check_ctl("div_start", 1'b1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            E_Instr = 32'h0;
            #1;
            check_val($sformatf("div_busy%0d_flag", k), {31'b0, mdu_busy}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check_ctl("div_reset_cycle", 1'b1);
        next_cycle();
        check_val("div_reset_busy", {31'b0, mdu_busy}, 32'd0);
        check_ctl("div_reset_nostall", 1'b0);
        check_val("div_reset_stall_cycles", stall_cycles, 32'd0);
        reset = 1'b0;
        D_Instr = 32'h0;
        next_cycle();

        // ---------------- lw -> beq, stall counter ----------------
        E_Instr = itype(6'h23, 0, 1, 16'h0);
        D_Instr = itype(6'h04, 1, 0, 16'h8);
        M_Instr = 32'h0;
        #2;
        check_ctl("cnt_lwE_beq", 1'b1);
        next_cycle();
        M_Instr = E_Instr;
        E_Instr = 32'h0;
        #1;
        check_ctl("cnt_lwM_beq", 1'b1);
`ifdef STALL_COUNT_EN
        check_val("cnt_after1", stall_cycles, 32'd1);
`else
        check_val("cnt_after1", stall_cycles, 32'd0);
`endif
        next_cycle();
        M_Instr = 32'h0;
        #1;
        check_ctl("cnt_beq_issue", 1'b0);
        next_cycle();
`ifdef STALL_COUNT_EN
        check_val("cnt_total", stall_cycles, 32'd2);
`else
        check_val("cnt_total", stall_cycles, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
